// File: rtl/data_ram_pkg.sv
// Shared definitions for the data memory: bus widths, control encodings and
// the access FSM state encoding.
package data_ram_pkg;

    localparam int DataBusW     = 32;
    localparam int DataAddrBusW = 32;

    localparam logic [DataBusW-1:0] ZeroWord = 32'h0000_0000;

    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } data_ram_state_e;

endpackage

// File: rtl/data_ram_array.sv
// Single-port word storage with byte-enabled synchronous write and
// combinational read of the addressed word. Contents are never reset.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [3:0]               sel,
    input  logic [DataBusW-1:0]      wdata,
    output logic [DataBusW-1:0]      rdata
);

    logic [DataBusW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_ram.sv
// Data memory with a configurable number of wait states. Handshake: ce is the
// request valid, held with stable we/addr/sel/data_i until ack; ack pulses for
// exactly one cycle (RESP) and the access completes there.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    we,
    input  logic [DataAddrBusW-1:0] addr,
    input  logic [3:0]              sel,
    input  logic [DataBusW-1:0]     data_i,
    output logic [DataBusW-1:0]     data_o,
    output logic                    ack,
    output logic                    stallreq,
    output data_ram_state_e         state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LastCount = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    data_ram_state_e     state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DataBusW-1:0] rd_hold_q;
    logic [DataBusW-1:0] rd_word;
    logic [AW-1:0]       idx;
    logic                wr_en;
    logic                addr_unused;

    // Byte offset and bits above the array wrap the address modulo DEPTH.
    assign idx         = addr[AW+1:2];
    assign addr_unused = ^{addr[DataAddrBusW-1:AW+2], addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            rd_hold_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_RESP && we == WriteDisable) begin
                rd_hold_q <= rd_word;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (ce == ChipEnable) begin
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (ce == ChipDisable) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == LastCount) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                // Completes even if ce was dropped during this cycle.
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign ack       = (state_q == S_RESP);
    assign stallreq  = ce & ~ack;
    assign wr_en     = ack & (we == WriteEnable);
    assign state_dbg = state_q;

    // Read data is live in the ack cycle and held afterwards.
    assign data_o = (ack && we == WriteDisable) ? rd_word : rd_hold_q;

    data_ram_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .wr_en(wr_en),
        .idx  (idx),
        .sel  (sel),
        .wdata(data_i),
        .rdata(rd_word)
    );

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: directed scenarios plus randomized accesses checked
// against a word-array model of the memory.
module tb_data_ram;
    import data_ram_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WC    = 2;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            ce, we, ack, stallreq;
    logic [31:0]     addr, data_i, data_o;
    logic [3:0]      sel;
    data_ram_state_e st_dbg;

    logic            ce0, we0, ack0, stallreq0;
    logic [31:0]     addr0, data_i0, data_o0;
    logic [3:0]      sel0;
    data_ram_state_e st_dbg0;

    data_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o), .ack(ack), .stallreq(stallreq),
        .state_dbg(st_dbg)
    );

    data_ram #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ce(ce0), .we(we0), .addr(addr0), .sel(sel0),
        .data_i(data_i0), .data_o(data_o0), .ack(ack0), .stallreq(stallreq0),
        .state_dbg(st_dbg0)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd = 32'h0;
    logic [31:0] exp_q[$];

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        int k;
        bit got;
        logic [31:0] e;
        @(negedge clk);
        ce = 1'b1; we = w; addr = a; sel = s; data_i = d;
        if (!w) exp_q.push_back(ref_mem[widx(a)]);
        got = 0;
        k = 0;
        while (!got && k < WC + 4) begin
            k++;
            @(negedge clk);
            check("stallreq", 32'(stallreq), 32'(ce & ~(k == WC + 1)));
            if (ack) begin
                got = 1;
                check("latency", 32'(k), 32'(WC + 1));
                if (!w) begin
                    e = exp_q.pop_front();
                    check("rd_data", data_o, e);
                    last_rd = e;
                end else begin
                    check("data_o_kept_on_write", data_o, last_rd);
                end
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        if (!got && !w) void'(exp_q.pop_front());
        ce = 1'b0;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
        end
        @(negedge clk);
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("data_o_hold", data_o, last_rd);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] v0;
        logic [31:0] a;
        ce = 0; we = 0; addr = 0; sel = 0; data_i = 0;
        ce0 = 0; we0 = 0; addr0 = 0; sel0 = 0; data_i0 = 0;
        rst = 1'b0;

        // Reset values; stallreq follows ce during reset.
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data_o", data_o, 32'h0);
        ce = 1'b1; #1;
        check("rst_stall_ce1", 32'(stallreq), 32'd1);
        ce = 1'b0; #1;
        check("rst_stall_ce0", 32'(stallreq), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Full-word write then read back.
        access(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
        access(1'b0, 32'h10, 4'b0000, 32'h0);
        // Byte-lane write.
        access(1'b1, 32'h10, 4'b0010, 32'h0000AA00);
        access(1'b0, 32'h10, 4'b1111, 32'h0);
        check("byte_lane_value", last_rd, 32'hDEADAAEF);
        // Empty byte-enable write leaves memory untouched.
        access(1'b1, 32'h10, 4'b0000, 32'h11111111);
        access(1'b0, 32'h10, 4'b0001, 32'h0);
        // Address wrap modulo DEPTH.
        access(1'b1, 32'h1000, 4'b1111, 32'h12345678);
        access(1'b0, 32'h0, 4'b1111, 32'h0);
        check("wrap_value", last_rd, 32'h12345678);

        // Aborted write: ce dropped while waiting.
        access(1'b1, 32'h20, 4'b1111, 32'h0BADCAFE);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; data_i = 32'hFFFFFFFF;
        @(negedge clk);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", 32'(ack), 32'd0);
        end
        access(1'b0, 32'h20, 4'b1111, 32'h0);

        // Reset in the middle of a write.
        access(1'b1, 32'h30, 4'b1111, 32'hA5A5A5A5);
        access(1'b0, 32'h30, 4'b1111, 32'h0);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h30; sel = 4'hF; data_i = 32'h0;
        @(negedge clk);
        rst = 1'b0; #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_data_o", data_o, 32'h0);
        check("midrst_stall", 32'(stallreq), 32'd1);
        @(negedge clk);
        ce = 1'b0; #1;
        check("midrst_stall_ce0", 32'(stallreq), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_rd = 32'h0;
        access(1'b0, 32'h30, 4'b1111, 32'h0);

        // Randomized accesses over a pre-initialised window, with junk in
        // the byte offset and the bits above the array.
        for (int i = 0; i < 64; i++) access(1'b1, i << 2, 4'hF, $urandom);
        for (int i = 0; i < 60; i++) begin
            a = ($urandom & 32'hFFFFF003) | (32'($urandom_range(0, 63)) << 2);
            access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end

        // Zero-wait instance: ce held high over two reads.
        v0 = $urandom;
        @(negedge clk);
        ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h14; sel0 = 4'hF; data_i0 = v0;
        @(negedge clk);
        check("wc0_wr_ack", 32'(ack0), 32'd1);
        ce0 = 1'b0;
        @(negedge clk);
        check("wc0_wr_idle", 32'(ack0), 32'd0);
        ce0 = 1'b1; we0 = 1'b0;
        @(negedge clk);
        check("wc0_rd1_ack", 32'(ack0), 32'd1);
        check("wc0_rd1_data", data_o0, v0);
        check("wc0_rd1_stall", 32'(stallreq0), 32'd0);
        @(negedge clk);
        check("wc0_gap_ack", 32'(ack0), 32'd0);
        check("wc0_gap_stall", 32'(stallreq0), 32'd1);
        @(negedge clk);
        check("wc0_rd2_ack", 32'(ack0), 32'd1);
        check("wc0_rd2_data", data_o0, v0);
        ce0 = 1'b0;
        @(negedge clk);
        check("wc0_end_ack", 32'(ack0), 32'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
